ifetch_requester: RTL and testbench
===================================

// Module: ifetch_requester
// PURPOSE
//  Instruction-fetch initiator on the CPU side of the instruction-memory controller (cache + backing memory).
//  Generates sequential word addresses and issues read requests, stalling while mem_ready is low.
//  Buffers returned words in a small FIFO and hands them to decode with a valid/ready handshake.
//  Handles pipeline redirects (branch/jump/trap) without disturbing an in-flight cache miss.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset; bits[1:0] must be 0
//  FIFO_DEPTH  2              instruction buffer entries; power of two, >= 2
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  reset            in   1   asynchronous, active-low reset
//  redirect_valid   in   1   flush the FIFO and restart fetch at redirect_pc
//  redirect_pc      in   32  new fetch address; bits[1:0] ignored (treated as 0)
//  mem_address      out  32  byte address of the current request, word aligned
//  mem_ren          out  1   read request
//  mem_wen          out  1   constant 0
//  mem_byte_select  out  4   constant 4'b1111
//  mem_ready        in   1   high = request completes this cycle; low = miss in progress
//  mem_rdata        in   32  read word, valid when mem_ren && mem_ready
//  inst_valid       out  1   FIFO head valid
//  inst_data        out  32  instruction at FIFO head
//  inst_pc          out  32  address of inst_data
//  inst_ready       in   1   decode accepts the head this cycle
//  stall_cycles     out  32  count of cycles with mem_ren && !mem_ready; saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (reset==0, asynchronous):
//  - state=FETCH, fetch_pc=RESET_PC, FIFO empty, mem_ren=0, mem_address=RESET_PC.
//  - inst_valid=0, inst_data=0, inst_pc=0, stall_cycles=0.
//  - Applies immediately, including mid-miss. The in-flight word is dropped.
//  Accept: posedge with mem_ren && mem_ready. mem_rdata is sampled at that edge.
//  Address stability: mem_address must not change while mem_ren && !mem_ready.
//  FSM (registered state; mem_ren and mem_address are combinational from state, fetch_pc and count):
//  - FETCH: mem_ren = (count < FIFO_DEPTH); mem_address = fetch_pc.
//    - accept -> push {fetch_pc, mem_rdata}; fetch_pc += 4, wrapping 32'hFFFF_FFFC -> 0.
//    - mem_ren && !mem_ready -> WAIT.
//  - WAIT: mem_ren=1; mem_address held.
//    - mem_ready -> push, fetch_pc += 4, back to FETCH.
//    - redirect_valid -> DISCARD.
//  - DISCARD: mem_ren=1; mem_address held at the old address.
//    - mem_ready -> word is NOT pushed; fetch_pc = saved redirect target; -> FETCH.
//  Redirect handling:
//  - Target is saved in a register. A later redirect while in DISCARD overwrites it; last one wins.
//  - In FETCH, redirect_valid: FIFO flushed; fetch_pc = redirect_pc & ~3 at the next edge.
//    - A same-cycle accept is dropped.
//    - mem_address switches only in the next cycle.
//  - In WAIT or DISCARD, redirect_valid flushes the FIFO in the same edge.
//  - Redirect beats any same-cycle push and pop. A pop in that cycle is discarded; decode must ignore it.
//  FIFO:
//  - count width = $clog2(FIFO_DEPTH)+1.
//  - inst_valid = (count != 0); inst_data and inst_pc come from the head register.
//  - No bypass: a word accepted at edge N is visible from edge N at the earliest.
//  - Fetch-to-decode latency is 1 cycle on a hit.
//  - Simultaneous push and pop: count is unchanged; order is preserved.
//  - Pointer wrap-around is modulo FIFO_DEPTH.
//  - Full: mem_ren=0 in FETCH. A pop in the same cycle does not re-enable mem_ren until the next cycle.
//  - Never push when full. This holds because WAIT only arises when count < FIFO_DEPTH.
//  - Pop when empty: ignored.
//  Throughput: one word per cycle while hitting and decode is ready.
//  stall_cycles increments in any state on mem_ren && !mem_ready.
// TESTING
//  1. Hold reset low, release -> 1st cycle: mem_ren=1, mem_address=0x0, inst_valid=0, stall_cycles=0.
//  2. mem_ready=1, inst_ready=1, rdata=addr^0xA5A5_0000 -> inst_pc 0,4,8,... one per cycle from cycle 2; data matches.
//  3. inst_ready=0 -> two words buffered (pc 0,4), mem_ren=0, mem_address=0x8; inst_ready=1 -> pc 0,4,8 in order.
//  4. mem_ready low 3 cycles on 0x4 -> mem_address stays 0x4, mem_ren=1, stall_cycles=3, no push until ready.
//  5. Redirect to 0x103 during a miss on 0x8 -> address held at 0x8 until ready; that word is dropped.
//     Next request and first delivered inst_pc are 0x100.
//  6. Reset asserted mid-miss, and fetch_pc=0xFFFF_FFFC wrap -> immediate reset values;
//     separately, after 0xFFFF_FFFC the next mem_address is 0x0.

Source files
------------

// File: rtl/ifetch_requester.sv
// Instruction-fetch initiator: issues sequential word reads, tolerates misses and redirects,
// and buffers returned words in a small FIFO toward decode.
module ifetch_requester #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_address,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [3:0]  mem_byte_select,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] stall_cycles
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StFetch, StWait, StDiscard} state_e;

    state_e          r_state, w_state_next;
    logic [31:0]     r_fetch_pc, w_fetch_pc_next;
    logic [31:0]     r_target, w_target_next;
    logic [31:0]     r_fifo_data [FIFO_DEPTH];
    logic [31:0]     r_fifo_pc   [FIFO_DEPTH];
    logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic [31:0]     r_stall_cycles;

    logic        w_has_room, w_ren, w_accept, w_stall, w_push, w_pop;
    logic [31:0] w_redirect_pc;

    assign w_has_room    = (r_count < CntW'(FIFO_DEPTH));
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_accept      = w_ren && mem_ready;
    assign w_stall       = w_ren && !mem_ready;
    assign w_pop         = inst_ready && (r_count != '0) && !redirect_valid;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StFetch;
            r_fetch_pc <= RESET_PC;
            r_target   <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_target   <= w_target_next;
        end
    end

    // Next-state logic; an outstanding request is always allowed to finish at its own address
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_target_next   = r_target;
        w_push          = 1'b0;
        unique case (r_state)
            StFetch: begin
                if (redirect_valid) begin
                    if (w_stall) begin
                        w_target_next = w_redirect_pc;
                        w_state_next  = StDiscard;
                    end else begin
                        w_fetch_pc_next = w_redirect_pc;
                    end
                end else if (w_accept) begin
                    w_push          = 1'b1;
                    w_fetch_pc_next = r_fetch_pc + 32'd4;
                end else if (w_stall) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (mem_ready) begin
                    w_state_next = StFetch;
                    if (redirect_valid) begin
                        w_fetch_pc_next = w_redirect_pc;
                    end else begin
                        w_push          = 1'b1;
                        w_fetch_pc_next = r_fetch_pc + 32'd4;
                    end
                end else if (redirect_valid) begin
                    w_target_next = w_redirect_pc;
                    w_state_next  = StDiscard;
                end
            end
            StDiscard: begin
                if (mem_ready) begin
                    w_state_next    = StFetch;
                    w_fetch_pc_next = redirect_valid ? w_redirect_pc : r_target;
                end else if (redirect_valid) begin
                    w_target_next = w_redirect_pc;
                end
            end
            default: w_state_next = StFetch;
        endcase
    end

    // Outputs
    always_comb begin
        w_ren = 1'b1;
        unique case (r_state)
            StFetch: w_ren = w_has_room;
            default: w_ren = 1'b1;
        endcase
    end

    assign mem_ren         = w_ren && reset;
    assign mem_address     = r_fetch_pc;
    assign mem_wen         = 1'b0;
    assign mem_byte_select = 4'b1111;
    assign inst_valid      = (r_count != '0);
    assign inst_data       = r_fifo_data[r_rd_ptr];
    assign inst_pc         = r_fifo_pc[r_rd_ptr];
    assign stall_cycles    = r_stall_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (w_push && !redirect_valid) begin
            r_fifo_data[r_wr_ptr] <= mem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_ifetch_requester.sv
// Randomized and directed bench for ifetch_requester against a transaction-level model.
module tb_ifetch_requester;

    localparam int unsigned Depth = 2;
    localparam logic [31:0] ResetPc = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] mem_address;
    logic        mem_ren;
    logic        mem_wen;
    logic [3:0]  mem_byte_select;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic [31:0] stall_cycles;

    ifetch_requester #(
        .RESET_PC   (ResetPc),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .mem_address     (mem_address),
        .mem_ren         (mem_ren),
        .mem_wen         (mem_wen),
        .mem_byte_select (mem_byte_select),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    // Model: queue of buffered words, next fetch address, and one possibly outstanding request
    entry_t      m_q[$];
    logic [31:0] m_fetch;
    logic [31:0] m_target;
    logic [31:0] m_stall;
    bit          m_pend;
    bit          m_drop;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_fetch  = ResetPc;
        m_target = '0;
        m_stall  = '0;
        m_pend   = 1'b0;
        m_drop   = 1'b0;
    endfunction

    function automatic bit model_ren();
        return m_pend || (m_q.size() < Depth);
    endfunction

    task automatic model_edge();
        bit ren;
        ren = model_ren();
        if (ren && !mem_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (redirect_valid) begin
            m_q.delete();
            if (ren && !mem_ready) begin
                m_pend   = 1'b1;
                m_drop   = 1'b1;
                m_target = redirect_pc & ~32'd3;
            end else begin
                m_pend  = 1'b0;
                m_drop  = 1'b0;
                m_fetch = redirect_pc & ~32'd3;
            end
        end else begin
            if (inst_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (ren && mem_ready) begin
                if (m_drop) begin
                    m_fetch = m_target;
                end else begin
                    m_q.push_back({m_fetch, mem_rdata});
                    m_fetch = m_fetch + 32'd4;
                end
                m_pend = 1'b0;
                m_drop = 1'b0;
            end else if (ren) begin
                m_pend = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("mem_ren", {31'b0, mem_ren}, {31'b0, model_ren()});
        chk("mem_address", mem_address, m_fetch);
        chk("mem_wen", {31'b0, mem_wen}, 32'd0);
        chk("byte_sel", {28'b0, mem_byte_select}, 32'hF);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_q.size() > 0});
        if (m_q.size() > 0) begin
            chk("inst_pc", inst_pc, m_q[0].pc);
            chk("inst_data", inst_data, m_q[0].data);
        end
        chk("stall_cycles", stall_cycles, m_stall);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n, input bit rv, input logic [31:0] rp, input bit mr,
                       input bit ir);
        for (int i = 0; i < n; i++) begin
            redirect_valid = rv;
            redirect_pc    = rp;
            mem_ready      = mr;
            inst_ready     = ir;
            mem_rdata      = m_fetch ^ 32'hA5A5_0000;
            step();
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ren"}, {31'b0, mem_ren}, 32'd0);
        chk({tag, "_addr"}, mem_address, ResetPc);
        chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
        chk({tag, "_data"}, inst_data, 32'd0);
        chk({tag, "_pc"}, inst_pc, 32'd0);
        chk({tag, "_stall"}, stall_cycles, 32'd0);
    endtask

    initial begin
        logic [31:0] stall0;
        model_reset();
        #12;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs();

        // Streaming hits with decode always ready
        run(8, 1'b0, '0, 1'b1, 1'b1);

        // Back-pressure fills the buffer and stops requests at 0x8
        run(1, 1'b1, 32'h0, 1'b1, 1'b0);
        run(2, 1'b0, '0, 1'b1, 1'b0);
        chk("bp_addr", mem_address, 32'h8);
        chk("bp_ren", {31'b0, mem_ren}, 32'd0);
        chk("bp_head", inst_pc, 32'h0);
        run(4, 1'b0, '0, 1'b1, 1'b1);

        // Three-cycle miss on 0x4
        run(1, 1'b1, 32'h0, 1'b1, 1'b1);
        run(1, 1'b0, '0, 1'b1, 1'b1);
        stall0 = stall_cycles;
        run(3, 1'b0, '0, 1'b0, 1'b1);
        chk("miss_addr", mem_address, 32'h4);
        chk("miss_stall", stall_cycles - stall0, 32'd3);
        run(1, 1'b0, '0, 1'b1, 1'b1);

        // Redirect during a miss on 0x8: old word dropped, fetch resumes at 0x100
        run(1, 1'b0, '0, 1'b0, 1'b1);
        run(1, 1'b1, 32'h103, 1'b0, 1'b1);
        run(2, 1'b0, '0, 1'b0, 1'b1);
        chk("disc_addr", mem_address, 32'h8);
        run(1, 1'b0, '0, 1'b1, 1'b1);
        chk("redir_addr", mem_address, 32'h100);
        chk("redir_novalid", {31'b0, inst_valid}, 32'd0);
        run(1, 1'b0, '0, 1'b1, 1'b1);
        chk("redir_pc", inst_pc, 32'h100);

        // Address wrap, then asynchronous reset during a miss
        run(1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        run(1, 1'b0, '0, 1'b1, 1'b1);
        chk("wrap_addr", mem_address, 32'h0);
        run(1, 1'b0, '0, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom;
            mem_ready      = ($urandom_range(0, 9) < 7);
            inst_ready     = ($urandom_range(0, 9) < 6);
            mem_rdata      = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
